// File: rtl/mem_req_arbiter_pkg.sv
// Shared constants for the memory request arbiter: FSM encoding, slot and
// source identifiers, bus widths and slot decode helpers.
package mem_req_arbiter_pkg;

  localparam int unsigned LINE_W = 128;
  localparam int unsigned MASK_W = 16;
  localparam int unsigned NSLOT  = 5;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT_W = 2'd2;
  localparam logic [1:0] S_WAIT_R = 2'd3;

  localparam logic [2:0] SLOT_UW = 3'd0;
  localparam logic [2:0] SLOT_UR = 3'd1;
  localparam logic [2:0] SLOT_DW = 3'd2;
  localparam logic [2:0] SLOT_DR = 3'd3;
  localparam logic [2:0] SLOT_IR = 3'd4;

  localparam logic [1:0] SRC_UART = 2'd0;
  localparam logic [1:0] SRC_DC   = 2'd1;
  localparam logic [1:0] SRC_IC   = 2'd2;

  function automatic logic [1:0] slot_src(input logic [2:0] slot);
    case (slot)
      SLOT_UW, SLOT_UR: slot_src = SRC_UART;
      SLOT_DW, SLOT_DR: slot_src = SRC_DC;
      default:          slot_src = SRC_IC;
    endcase
  endfunction

  function automatic logic slot_is_wr(input logic [2:0] slot);
    slot_is_wr = (slot == SLOT_UW) || (slot == SLOT_DW);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Downstream memory request port shared by all requesters; the arbiter is
// the master, the AXI bus master block is the slave.
interface mem_req_arbiter_if;
  import mem_req_arbiter_pkg::*;

  logic              m_wstart_rq;
  logic [31:0]       m_win_addr;
  logic [LINE_W-1:0] m_in_wdata;
  logic [MASK_W-1:0] m_in_mask;
  logic              m_finish_wresp;
  logic              m_rstart_rq;
  logic [31:0]       m_rin_addr;
  logic [LINE_W-1:0] m_rdat_m_data;
  logic              m_rdat_m_valid;
  logic              m_finish_mrd;

  modport master (
    output m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
    input  m_finish_wresp, m_rdat_m_data, m_rdat_m_valid, m_finish_mrd
  );

  modport slave (
    input  m_wstart_rq, m_win_addr, m_in_wdata, m_in_mask, m_rstart_rq, m_rin_addr,
    output m_finish_wresp, m_rdat_m_data, m_rdat_m_valid, m_finish_mrd
  );

endinterface

// File: rtl/mem_req_arbiter_req_slot.sv
// One pending-request holding register: loads on a start pulse, clears on
// grant, and flags a pulse that lands on an already occupied slot.
module req_slot
  import mem_req_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic [MASK_W-1:0] mask_i,
  output logic              valid_o,
  output logic [31:0]       addr_o,
  output logic [LINE_W-1:0] data_o,
  output logic [MASK_W-1:0] mask_o,
  output logic              overrun_o
);

  logic              valid_q, valid_d;
  logic [31:0]       addr_q, addr_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic [MASK_W-1:0] mask_q, mask_d;

  // A slot being granted this cycle is free, so a pulse then is accepted.
  assign overrun_o = load_i & valid_q & ~clr_i;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (load_i && (!valid_q || clr_i)) begin
      valid_d = 1'b1;
      addr_d  = addr_i;
      data_d  = data_i;
      mask_d  = mask_i;
    end else if (clr_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= 32'h0;
      data_q  <= {LINE_W{1'b0}};
      mask_q  <= {MASK_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign mask_o  = mask_q;

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates UART loader, D-cache and I-cache onto one memory request port,
// routes completions back to the winner, with a watchdog and sticky errors.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned TW      = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_calib_complete,
  input  logic              u_wstart_rq,
  input  logic              d_wstart_rq,
  input  logic [31:0]       u_win_addr,
  input  logic [31:0]       d_win_addr,
  input  logic [LINE_W-1:0] u_in_wdata,
  input  logic [LINE_W-1:0] d_in_wdata,
  input  logic [MASK_W-1:0] u_in_mask,
  input  logic [MASK_W-1:0] d_in_mask,
  input  logic              u_rstart_rq,
  input  logic              d_rstart_rq,
  input  logic              i_rstart_rq,
  input  logic [31:0]       u_rin_addr,
  input  logic [31:0]       d_rin_addr,
  input  logic [31:0]       i_rin_addr,
  output logic              u_finish_wresp,
  output logic              d_finish_wresp,
  output logic              u_rdat_m_valid,
  output logic              d_rdat_m_valid,
  output logic              i_rdat_m_valid,
  output logic [LINE_W-1:0] rdat_m_data,
  output logic              u_finish_mrd,
  output logic              d_finish_mrd,
  output logic              i_finish_mrd,
  mem_req_arbiter_if.master bus,
  input  logic              err_clr,
  output logic              err_overrun,
  output logic              err_timeout
);

  logic [NSLOT-1:0]  load_s, clr_s, valid_s, ovr_s;
  logic [31:0]       in_addr_s [NSLOT];
  logic [LINE_W-1:0] in_data_s [NSLOT];
  logic [MASK_W-1:0] in_mask_s [NSLOT];
  logic [31:0]       addr_s    [NSLOT];
  logic [LINE_W-1:0] data_s    [NSLOT];
  logic [MASK_W-1:0] mask_s    [NSLOT];

  assign load_s = {i_rstart_rq, d_rstart_rq, d_wstart_rq, u_rstart_rq, u_wstart_rq};
  assign in_addr_s[SLOT_UW] = u_win_addr;  assign in_data_s[SLOT_UW] = u_in_wdata;
  assign in_addr_s[SLOT_UR] = u_rin_addr;  assign in_data_s[SLOT_UR] = {LINE_W{1'b0}};
  assign in_addr_s[SLOT_DW] = d_win_addr;  assign in_data_s[SLOT_DW] = d_in_wdata;
  assign in_addr_s[SLOT_DR] = d_rin_addr;  assign in_data_s[SLOT_DR] = {LINE_W{1'b0}};
  assign in_addr_s[SLOT_IR] = i_rin_addr;  assign in_data_s[SLOT_IR] = {LINE_W{1'b0}};
  assign in_mask_s[SLOT_UW] = u_in_mask;
  assign in_mask_s[SLOT_UR] = {MASK_W{1'b0}};
  assign in_mask_s[SLOT_DW] = d_in_mask;
  assign in_mask_s[SLOT_DR] = {MASK_W{1'b0}};
  assign in_mask_s[SLOT_IR] = {MASK_W{1'b0}};

  for (genvar g = 0; g < NSLOT; g++) begin : g_slot
    req_slot u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (load_s[g]),
      .clr_i    (clr_s[g]),
      .addr_i   (in_addr_s[g]),
      .data_i   (in_data_s[g]),
      .mask_i   (in_mask_s[g]),
      .valid_o  (valid_s[g]),
      .addr_o   (addr_s[g]),
      .data_o   (data_s[g]),
      .mask_o   (mask_s[g]),
      .overrun_o(ovr_s[g])
    );
  end

  logic [1:0]        state_q, state_d, rr_q, rr_d;
  logic [2:0]        win_slot_q, win_slot_d, sel_slot_s;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic              m_wstart_q, m_wstart_d, m_rstart_q, m_rstart_d;
  logic [31:0]       m_waddr_q, m_waddr_d, m_raddr_q, m_raddr_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
  logic [MASK_W-1:0] m_mask_q, m_mask_d;
  logic              err_ovr_q, err_ovr_d, err_tmo_q, err_tmo_d;
  logic              grant_s, fin_in_s, tmo_s, done_s, d_any_s;
  logic [1:0]        win_src_s, sel_src_s;

  // UART first, then caches by round-robin (rr_q names the favoured cache); write before read.
  always_comb begin
    d_any_s = valid_s[SLOT_DW] | valid_s[SLOT_DR];
    if (valid_s[SLOT_UW]) begin
      sel_slot_s = SLOT_UW;
    end else if (valid_s[SLOT_UR]) begin
      sel_slot_s = SLOT_UR;
    end else if (d_any_s && (!valid_s[SLOT_IR] || rr_q == SRC_DC)) begin
      sel_slot_s = valid_s[SLOT_DW] ? SLOT_DW : SLOT_DR;
    end else begin
      sel_slot_s = SLOT_IR;
    end
  end

  assign sel_src_s = slot_src(sel_slot_s);
  assign win_src_s = slot_src(win_slot_q);
  assign grant_s   = (state_q == S_IDLE) & init_calib_complete & (|valid_s);
  assign fin_in_s  = ((state_q == S_WAIT_W) & bus.m_finish_wresp) |
                     ((state_q == S_WAIT_R) & bus.m_finish_mrd);
  assign tmo_s     = ((state_q == S_WAIT_W) | (state_q == S_WAIT_R)) & ~fin_in_s &
                     (cnt_q == TW'(TIMEOUT - 1));
  assign done_s    = fin_in_s | tmo_s;

  // Transaction FSM, downstream issue registers and watchdog count.
  always_comb begin
    state_d    = state_q;
    win_slot_d = win_slot_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    m_wstart_d = 1'b0;
    m_rstart_d = 1'b0;
    m_waddr_d  = m_waddr_q;
    m_wdata_d  = m_wdata_q;
    m_mask_d   = m_mask_q;
    m_raddr_d  = m_raddr_q;
    clr_s      = {NSLOT{1'b0}};
    case (state_q)
      S_IDLE: begin
        cnt_d = {TW{1'b0}};
        if (grant_s) begin
          state_d    = S_ISSUE;
          win_slot_d = sel_slot_s;
          if (slot_is_wr(sel_slot_s)) begin
            m_wstart_d = 1'b1;
            m_waddr_d  = addr_s[sel_slot_s];
            m_wdata_d  = data_s[sel_slot_s];
            m_mask_d   = mask_s[sel_slot_s];
          end else begin
            m_rstart_d = 1'b1;
            m_raddr_d  = addr_s[sel_slot_s];
          end
          if (sel_src_s == SRC_DC)      rr_d = SRC_IC;
          else if (sel_src_s == SRC_IC) rr_d = SRC_DC;
          else                          rr_d = rr_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        clr_s[win_slot_q] = 1'b1;
        cnt_d   = cnt_q + TW'(1);
        state_d = slot_is_wr(win_slot_q) ? S_WAIT_W : S_WAIT_R;
      end
      S_WAIT_W, S_WAIT_R: begin
        if (done_s) state_d = S_IDLE;
        else        cnt_d   = cnt_q + TW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sticky error flags; a new event wins over a simultaneous clear.
  always_comb begin
    err_ovr_d = (|ovr_s) | (err_ovr_q & ~err_clr);
    err_tmo_d = tmo_s | (err_tmo_q & ~err_clr);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      win_slot_q <= SLOT_UW;
      rr_q       <= SRC_DC;
      cnt_q      <= {TW{1'b0}};
      m_wstart_q <= 1'b0;
      m_rstart_q <= 1'b0;
      m_waddr_q  <= 32'h0;
      m_wdata_q  <= {LINE_W{1'b0}};
      m_mask_q   <= {MASK_W{1'b0}};
      m_raddr_q  <= 32'h0;
      err_ovr_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_slot_q <= win_slot_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      m_wstart_q <= m_wstart_d;
      m_rstart_q <= m_rstart_d;
      m_waddr_q  <= m_waddr_d;
      m_wdata_q  <= m_wdata_d;
      m_mask_q   <= m_mask_d;
      m_raddr_q  <= m_raddr_d;
      err_ovr_q  <= err_ovr_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  assign bus.m_wstart_rq = m_wstart_q;
  assign bus.m_rstart_rq = m_rstart_q;
  assign bus.m_win_addr  = m_waddr_q;
  assign bus.m_in_wdata  = m_wdata_q;
  assign bus.m_in_mask   = m_mask_q;
  assign bus.m_rin_addr  = m_raddr_q;
  assign err_overrun     = err_ovr_q;
  assign err_timeout     = err_tmo_q;
  assign rdat_m_data     = bus.m_rdat_m_data;

  // Completions go to the winner only; a watchdog abort looks like a finish.
  assign u_finish_wresp = (state_q == S_WAIT_W) & done_s & (win_src_s == SRC_UART);
  assign d_finish_wresp = (state_q == S_WAIT_W) & done_s & (win_src_s == SRC_DC);
  assign u_finish_mrd   = (state_q == S_WAIT_R) & done_s & (win_src_s == SRC_UART);
  assign d_finish_mrd   = (state_q == S_WAIT_R) & done_s & (win_src_s == SRC_DC);
  assign i_finish_mrd   = (state_q == S_WAIT_R) & done_s & (win_src_s == SRC_IC);
  assign u_rdat_m_valid = (state_q == S_WAIT_R) & bus.m_rdat_m_valid & (win_src_s == SRC_UART);
  assign d_rdat_m_valid = (state_q == S_WAIT_R) & bus.m_rdat_m_valid & (win_src_s == SRC_DC);
  assign i_rdat_m_valid = (state_q == S_WAIT_R) & bus.m_rdat_m_valid & (win_src_s == SRC_IC);

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: directed requests push expected
// downstream issues and upstream strobes; negedge monitors pop and compare.
module tb_mem_req_arbiter;
  import mem_req_arbiter_pkg::*;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  mask;
  } dn_t;

  typedef struct {
    logic [7:0]   vec;
    logic [127:0] data;
  } up_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_calib_complete = 1'b1;
  logic u_wstart_rq = 1'b0, d_wstart_rq = 1'b0;
  logic [31:0] u_win_addr = 32'h0, d_win_addr = 32'h0;
  logic [127:0] u_in_wdata = 128'h0, d_in_wdata = 128'h0;
  logic [15:0] u_in_mask = 16'h0, d_in_mask = 16'h0;
  logic u_rstart_rq = 1'b0, d_rstart_rq = 1'b0, i_rstart_rq = 1'b0;
  logic [31:0] u_rin_addr = 32'h0, d_rin_addr = 32'h0, i_rin_addr = 32'h0;
  logic u_finish_wresp, d_finish_wresp;
  logic u_rdat_m_valid, d_rdat_m_valid, i_rdat_m_valid;
  logic [127:0] rdat_m_data;
  logic u_finish_mrd, d_finish_mrd, i_finish_mrd;
  logic err_clr = 1'b0;
  logic err_overrun, err_timeout;

  int tests_run = 0;
  int tests_failed = 0;
  dn_t dn_q[$];
  up_t up_q[$];

  mem_req_arbiter_if bus();

  mem_req_arbiter #(.TIMEOUT(16), .TW(13)) dut (
    .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
    .u_wstart_rq(u_wstart_rq), .d_wstart_rq(d_wstart_rq),
    .u_win_addr(u_win_addr), .d_win_addr(d_win_addr),
    .u_in_wdata(u_in_wdata), .d_in_wdata(d_in_wdata),
    .u_in_mask(u_in_mask), .d_in_mask(d_in_mask),
    .u_rstart_rq(u_rstart_rq), .d_rstart_rq(d_rstart_rq), .i_rstart_rq(i_rstart_rq),
    .u_rin_addr(u_rin_addr), .d_rin_addr(d_rin_addr), .i_rin_addr(i_rin_addr),
    .u_finish_wresp(u_finish_wresp), .d_finish_wresp(d_finish_wresp),
    .u_rdat_m_valid(u_rdat_m_valid), .d_rdat_m_valid(d_rdat_m_valid),
    .i_rdat_m_valid(i_rdat_m_valid), .rdat_m_data(rdat_m_data),
    .u_finish_mrd(u_finish_mrd), .d_finish_mrd(d_finish_mrd), .i_finish_mrd(i_finish_mrd),
    .bus(bus), .err_clr(err_clr), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] up_now();
    return {u_finish_wresp, d_finish_wresp, u_rdat_m_valid, d_rdat_m_valid,
            i_rdat_m_valid, u_finish_mrd, d_finish_mrd, i_finish_mrd};
  endfunction

  // kind 0 = write finish, 1 = read valid, 2 = read finish
  function automatic logic [7:0] upv(input int kind, input logic [1:0] src);
    logic [7:0] v;
    v = 8'h00;
    case (kind)
      0:       v[7 - int'(src)] = 1'b1;
      1:       v[5 - int'(src)] = 1'b1;
      default: v[2 - int'(src)] = 1'b1;
    endcase
    return v;
  endfunction

  task automatic push_dn(input logic wr, input logic [31:0] a, input logic [127:0] d, input logic [15:0] m);
    dn_t e;
    e.wr = wr; e.addr = a; e.data = d; e.mask = m;
    dn_q.push_back(e);
  endtask

  task automatic push_up(input logic [7:0] v, input logic [127:0] d);
    up_t e;
    e.vec = v; e.data = d;
    up_q.push_back(e);
  endtask

  // Downstream issue monitor.
  always @(negedge clk) begin
    if (rst_n && (bus.m_wstart_rq || bus.m_rstart_rq)) begin
      if (dn_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL dn_unexpected: got start w=%0b r=%0b, required none", bus.m_wstart_rq, bus.m_rstart_rq);
      end else begin
        dn_t e;
        e = dn_q.pop_front();
        if (e.wr)
          check("dn_write", {2'b0, bus.m_wstart_rq, bus.m_rstart_rq, 12'h0, bus.m_win_addr, bus.m_in_wdata, bus.m_in_mask},
                {2'b0, 2'b10, 12'h0, e.addr, e.data, e.mask});
        else
          check("dn_read", {bus.m_wstart_rq, bus.m_rstart_rq, bus.m_rin_addr}, {2'b01, e.addr});
      end
    end
  end

  // Upstream strobe monitor.
  always @(negedge clk) begin
    if (rst_n && (up_now() != 8'h00)) begin
      if (up_q.size() == 0) begin
        tests_run++; tests_failed++;
        $display("FAIL up_unexpected: got strobes %b, required none", up_now());
      end else begin
        up_t e;
        e = up_q.pop_front();
        check("up_strobe", up_now(), e.vec);
        if (e.vec[5:3] != 3'b000) check("up_data", rdat_m_data, e.data);
      end
    end
  end

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.m_wstart_rq || bus.m_rstart_rq) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("wait_start", ok, 1'b1);
  endtask

  task automatic serve(input bit wr, input logic [1:0] src, input logic [127:0] d);
    bit ok;
    wait_start(ok);
    if (ok) begin
      tick();
      if (wr) begin
        push_up(upv(0, src), 128'h0);
        bus.m_finish_wresp = 1'b1; tick(); bus.m_finish_wresp = 1'b0;
      end else begin
        push_up(upv(1, src), d);
        bus.m_rdat_m_data = d; bus.m_rdat_m_valid = 1'b1; tick(); bus.m_rdat_m_valid = 1'b0;
        push_up(upv(2, src), 128'h0);
        bus.m_finish_mrd = 1'b1; tick(); bus.m_finish_mrd = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dn"}, {bus.m_wstart_rq, bus.m_rstart_rq, bus.m_win_addr, bus.m_rin_addr,
                          bus.m_in_mask, err_overrun, err_timeout}, 192'h0);
    check({name, "_wdata"}, bus.m_in_wdata, 192'h0);
    check({name, "_up"}, up_now(), 192'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, required $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    bit seen;
    bus.m_finish_wresp = 1'b0; bus.m_finish_mrd = 1'b0;
    bus.m_rdat_m_valid = 1'b0; bus.m_rdat_m_data = 128'h0;
    #1;
    check_all_zero("reset");
    do_reset();
    check_all_zero("post_reset");

    // Single D-cache read with start latency.
    push_dn(1'b0, 32'h0000_1000, 128'h0, 16'h0);
    d_rin_addr = 32'h0000_1000; d_rstart_rq = 1'b1; tick(); d_rstart_rq = 1'b0;
    check("lat_t1", bus.m_rstart_rq, 1'b0);
    tick();
    check("lat_t2", bus.m_rstart_rq, 1'b1);
    serve(1'b0, SRC_DC, 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF);

    // Simultaneous requests: Ur, Dw, Ir, Dr.
    do_reset();
    push_dn(1'b0, 32'h5000_0000, 128'h0, 16'h0);
    push_dn(1'b1, 32'h4000_0000, {4{32'h1111_2222}}, 16'hF0F0);
    push_dn(1'b0, 32'h6000_0000, 128'h0, 16'h0);
    push_dn(1'b0, 32'h7000_0000, 128'h0, 16'h0);
    u_rin_addr = 32'h5000_0000; d_win_addr = 32'h4000_0000; d_in_wdata = {4{32'h1111_2222}};
    d_in_mask = 16'hF0F0; i_rin_addr = 32'h6000_0000; d_rin_addr = 32'h7000_0000;
    u_rstart_rq = 1'b1; d_wstart_rq = 1'b1; d_rstart_rq = 1'b1; i_rstart_rq = 1'b1;
    tick();
    u_rstart_rq = 1'b0; d_wstart_rq = 1'b0; d_rstart_rq = 1'b0; i_rstart_rq = 1'b0;
    serve(1'b0, SRC_UART, {4{32'hA0A0_0001}});
    serve(1'b1, SRC_DC, 128'h0);
    serve(1'b0, SRC_IC, {4{32'hA0A0_0002}});
    serve(1'b0, SRC_DC, {4{32'hA0A0_0003}});

    // Round-robin fairness: D and I re-request after every finish.
    do_reset();
    for (int k = 0; k < 10; k++)
      push_dn(1'b0, ((k % 2) == 0 ? 32'h2000_0000 : 32'h3000_0000) + 32'(k), 128'h0, 16'h0);
    d_rin_addr = 32'h2000_0000; i_rin_addr = 32'h3000_0001;
    d_rstart_rq = 1'b1; i_rstart_rq = 1'b1; tick(); d_rstart_rq = 1'b0; i_rstart_rq = 1'b0;
    for (int k = 0; k < 10; k++) begin
      serve(1'b0, (k % 2) == 0 ? SRC_DC : SRC_IC, {4{32'hC0DE_0000 + 32'(k)}});
      if (k + 2 < 10) begin
        if ((k % 2) == 0) begin
          d_rin_addr = 32'h2000_0000 + 32'(k + 2); d_rstart_rq = 1'b1; tick(); d_rstart_rq = 1'b0;
        end else begin
          i_rin_addr = 32'h3000_0000 + 32'(k + 2); i_rstart_rq = 1'b1; tick(); i_rstart_rq = 1'b0;
        end
      end
    end

    // Overrun while Ir is held pending by calibration.
    init_calib_complete = 1'b0;
    i_rin_addr = 32'h0000_A000; i_rstart_rq = 1'b1; tick(); i_rstart_rq = 1'b0;
    tick();
    check("ovr_before", err_overrun, 1'b0);
    i_rin_addr = 32'h0000_B000; i_rstart_rq = 1'b1; tick(); i_rstart_rq = 1'b0;
    check("ovr_set", err_overrun, 1'b1);
    push_dn(1'b0, 32'h0000_A000, 128'h0, 16'h0);
    init_calib_complete = 1'b1;
    serve(1'b0, SRC_IC, {4{32'h0BAD_F00D}});
    check("ovr_sticky", err_overrun, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovr_clr", err_overrun, 1'b0);

    // Finish strobes in IDLE are ignored.
    bus.m_finish_wresp = 1'b1; bus.m_finish_mrd = 1'b1; bus.m_rdat_m_valid = 1'b1;
    #2;
    check("idle_finish", up_now(), 8'h00);
    tick();
    bus.m_finish_wresp = 1'b0; bus.m_finish_mrd = 1'b0; bus.m_rdat_m_valid = 1'b0;

    // Watchdog abort on a D-cache write, then the pending Ir is serviced.
    push_dn(1'b1, 32'h0000_C000, {4{32'h5A5A_A5A5}}, 16'h00FF);
    push_dn(1'b0, 32'h0000_D000, 128'h0, 16'h0);
    d_win_addr = 32'h0000_C000; d_in_wdata = {4{32'h5A5A_A5A5}}; d_in_mask = 16'h00FF;
    d_wstart_rq = 1'b1; tick(); d_wstart_rq = 1'b0;
    i_rin_addr = 32'h0000_D000; i_rstart_rq = 1'b1; tick(); i_rstart_rq = 1'b0;
    wait_start(ok);
    push_up(upv(0, SRC_DC), 128'h0);
    repeat (14) tick();
    check("tmo_early", d_finish_wresp, 1'b0);
    tick();
    check("tmo_pulse", d_finish_wresp, 1'b1);
    tick();
    check("tmo_flag", err_timeout, 1'b1);
    serve(1'b0, SRC_IC, {4{32'h7777_8888}});
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("tmo_clr", err_timeout, 1'b0);

    // Calibration gating.
    init_calib_complete = 1'b0;
    push_dn(1'b1, 32'h0000_E000, {4{32'h1234_5678}}, 16'hFFFF);
    u_win_addr = 32'h0000_E000; u_in_wdata = {4{32'h1234_5678}}; u_in_mask = 16'hFFFF;
    u_wstart_rq = 1'b1; tick(); u_wstart_rq = 1'b0;
    seen = 1'b0;
    repeat (5) begin tick(); seen |= bus.m_wstart_rq; end
    check("calib_block", seen, 1'b0);
    init_calib_complete = 1'b1;
    tick();
    check("calib_grant", bus.m_wstart_rq, 1'b1);
    serve(1'b1, SRC_UART, 128'h0);

    // Asynchronous reset in WAIT_R clears everything without a finish.
    push_dn(1'b0, 32'h0000_F000, 128'h0, 16'h0);
    d_rin_addr = 32'h0000_F000; d_rstart_rq = 1'b1; tick(); d_rstart_rq = 1'b0;
    i_rin_addr = 32'h0000_F100; i_rstart_rq = 1'b1; tick(); i_rstart_rq = 1'b0;
    wait_start(ok);
    tick();
    bus.m_rdat_m_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick(); rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin tick(); seen |= bus.m_wstart_rq | bus.m_rstart_rq; end
    check("rst_slots_empty", seen, 1'b0);

    check("dn_q_empty", dn_q.size(), 0);
    check("up_q_empty", up_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single memory request port of the AXI bus master between three requesters: UART loader (source 0, read+write), D-cache (source 1, read+write), I-cache (source 2, read only).
- Latches one-cycle start pulses from each requester, picks one transaction at a time and re-issues it as a one-cycle start pulse downstream.
- Routes the write-response, read-data and finish strobes back to the winning requester only.
- Adds a transaction watchdog and sticky error flags.

Parameters:
- TIMEOUT, 4096, cycles a granted transaction may wait for its finish strobe before abort.
- TW, 13, width of the watchdog counter. It must hold TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_calib_complete  in  1  memory ready; no grant while low
- u_wstart_rq, d_wstart_rq  in  1  write start pulse (UART, D-cache)
- u_win_addr, d_win_addr  in  32  write address
- u_in_wdata, d_in_wdata  in  128  write data line
- u_in_mask, d_in_mask  in  16  write byte mask
- u_rstart_rq, d_rstart_rq, i_rstart_rq  in  1  read start pulse
- u_rin_addr, d_rin_addr, i_rin_addr  in  32  read address
- u_finish_wresp, d_finish_wresp  out  1  write complete pulse
- u_rdat_m_valid, d_rdat_m_valid, i_rdat_m_valid  out  1  read beat valid
- rdat_m_data  out  128  read data, shared by all sources; qualify with the per-source valid
- u_finish_mrd, d_finish_mrd, i_finish_mrd  out  1  read complete pulse
- m_wstart_rq  out  1  downstream write start pulse
- m_win_addr  out  32  downstream write address
- m_in_wdata  out  128  downstream write data
- m_in_mask  out  16  downstream write mask
- m_finish_wresp  in  1  downstream write done
- m_rstart_rq  out  1  downstream read start pulse
- m_rin_addr  out  32  downstream read address
- m_rdat_m_data  in  128  downstream read data
- m_rdat_m_valid  in  1  downstream read beat valid
- m_finish_mrd  in  1  downstream read done
- err_clr  in  1  clears the sticky error flags
- err_overrun  out  1  sticky: start pulse arrived while the same slot was already pending
- err_timeout  out  1  sticky: watchdog abort occurred

Behaviour:
- Reset values: all outputs 0; pending slots empty; FSM in IDLE; round-robin pointer set to D-cache.
- Slots: 5 holding slots (Uw, Ur, Dw, Dr, Ir), each with a valid bit plus its address, data and mask.
  - A start pulse loads its slot at the next edge.
  - A pulse on a slot that is already valid is ignored and sets err_overrun.
- FSM states: IDLE, ISSUE, WAIT_W, WAIT_R.
- IDLE: if init_calib_complete=1 and any slot is valid, select the winner, register it, go to ISSUE.
  - Priority 1: UART above the caches.
  - Priority 2: D-cache vs I-cache by round-robin; the last-granted cache loses a tie.
  - Within one source, the write slot beats the read slot.
- ISSUE: hold for exactly 1 cycle.
  - Drive m_wstart_rq or m_rstart_rq = 1, with m_* address/data/mask taken from the winning slot.
  - Clear that slot's valid bit.
  - Go to WAIT_W or WAIT_R.
  - m_* address/data/mask hold their value until the next ISSUE.
- WAIT_W: on m_finish_wresp, pulse the winner's *_finish_wresp combinationally in the same cycle, then go to IDLE.
- WAIT_R: route m_rdat_m_valid combinationally to the winner's *_rdat_m_valid only.
  - rdat_m_data = m_rdat_m_data at all times.
  - On m_finish_mrd, pulse the winner's *_finish_mrd in the same cycle, then go to IDLE.
- Round-robin pointer updates only when a cache is granted.
- Latency: request pulse at cycle t with FSM idle gives the downstream start pulse at cycle t+2. Back-to-back transactions are separated by at least 1 IDLE cycle.
- A new request arriving in the same cycle as a finish is latched normally.
- Finish strobes arriving in IDLE or ISSUE are ignored.
- Watchdog:
  - The counter clears at ISSUE and increments in WAIT_*.
  - When it reaches TIMEOUT-1 without a finish, pulse the winner's finish strobe (read valid stays 0), set err_timeout, go to IDLE.
  - A finish arriving on that same cycle takes precedence: normal completion, no error.
- err_clr clears both flags. If err_clr and a new error event occur in the same cycle, the flag stays set.
- init_calib_complete falling low does not abort a transaction in flight; it only blocks new grants.
- Asynchronous reset mid-transaction returns everything to reset state immediately; no finish pulse is generated.

Decomposition:
- Shared package holds:
  - FSM state encoding constants.
  - Slot index constants SLOT_UW..SLOT_IR.
  - Source IDs SRC_UART=0, SRC_DC=1, SRC_IC=2.
  - Line width 128 and mask width 16.
- Sub-module req_slot: one holding register with valid, load on pulse, clear on grant and overrun detect.
  - Instantiated 5 times; the read-only slots tie their data/mask inputs to 0.

Test Plan:
- Single DC read: d_rstart_rq pulse at t with d_rin_addr=0x0000_1000 → m_rstart_rq=1 at t+2 with m_rin_addr=0x0000_1000. Then m_rdat_m_valid with data 0xDEAD…BEEF → d_rdat_m_valid=1 and rdat_m_data matches, i/u valid=0. m_finish_mrd → d_finish_mrd same cycle.
- Simultaneous d_wstart_rq, d_rstart_rq, i_rstart_rq, u_rstart_rq in one cycle → downstream order Ur, Dw, Ir, Dr. The round-robin pointer moves to Ir after Dw, so Ir is granted before Dr.
- Round-robin fairness: D-cache and I-cache each re-request immediately after every finish for 10 transactions → grants alternate D, I, D, I…
- Overrun: i_rstart_rq twice while Ir is pending → err_overrun=1, only one downstream read issued. err_clr pulse → err_overrun=0.
- Timeout with TIMEOUT=16: write issued and m_finish_wresp never returned → d_finish_wresp pulses 15 cycles after ISSUE, err_timeout=1, next pending request is then serviced.
- Calibration gating: init_calib_complete=0 with u_wstart_rq pending → no m_wstart_rq. Raise it → m_wstart_rq 1 cycle later. Assert rst_n=0 in WAIT_R → all outputs 0 and slots empty after reset.
